// File: rtl/snes_mem_pkg.sv
// Shared definitions for the cartridge memory path: arbiter states, owner
// encoding and the byte-lane selector reused by the mapper modules.
package snes_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_COP = 1'b1;

    // Byte reads return the addressed lane in [7:0] with [15:8] cleared.
    function automatic logic [15:0] byte_lane_sel(input logic [15:0] data,
                                                  input logic        word,
                                                  input logic        a0);
        logic [15:0] res;
        if (word) begin
            res = data;
        end else if (a0) begin
            res = {8'h00, data[15:8]};
        end else begin
            res = {8'h00, data[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the cartridge ROM port: CPU mapper path has priority,
// coprocessor fetch is guaranteed a grant after MAX_SKIP consecutive CPU grants.
module rom_port_arbiter
    import snes_mem_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int MAX_SKIP = 3
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              refresh,
    input  logic [ADDR_W-1:0] rom_mask,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_word,
    output logic              cpu_ack,
    output logic [15:0]       cpu_q,
    input  logic              cop_req,
    input  logic [ADDR_W-1:0] cop_addr,
    input  logic              cop_word,
    output logic              cop_ack,
    output logic [15:0]       cop_q,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_word,
    input  logic              rom_ack,
    input  logic [15:0]       rom_q,
    output logic              busy,
    output logic              owner
);

    localparam logic [3:0] SKIP_MAX = 4'(MAX_SKIP);

    arb_state_e        state_q, state_d;
    logic              rom_req_q, rom_req_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_word_q, rom_word_d;
    logic              owner_q, owner_d;
    logic [3:0]        skip_q, skip_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cop_ack_q, cop_ack_d;
    logic [15:0]       cpu_q_q, cpu_q_d;
    logic [15:0]       cop_q_q, cop_q_d;
    logic              busy_q, busy_d;
    logic              cop_win_s;
    logic [15:0]       lane_s;

    assign cop_win_s = cop_req && (!cpu_req || (skip_q == SKIP_MAX));
    assign lane_s    = byte_lane_sel(rom_q, rom_word_q, rom_addr_q[0]);

    // Next-state, grant loading, skip counting and read-data capture.
    always_comb begin
        state_d    = state_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;
        rom_word_d = rom_word_q;
        owner_d    = owner_q;
        skip_d     = skip_q;
        cpu_ack_d  = 1'b0;
        cop_ack_d  = 1'b0;
        cpu_q_d    = cpu_q_q;
        cop_q_d    = cop_q_q;
        case (state_q)
            IDLE: begin
                if (!refresh && (cpu_req || cop_req)) begin
                    rom_req_d = 1'b1;
                    state_d   = GRANT;
                    if (cop_win_s) begin
                        rom_addr_d = cop_addr & rom_mask;
                        rom_word_d = cop_word;
                        owner_d    = OWNER_COP;
                        skip_d     = 4'd0;
                    end else begin
                        rom_addr_d = cpu_addr & rom_mask;
                        rom_word_d = cpu_word;
                        owner_d    = OWNER_CPU;
                        // Only CPU grants that bypass a waiting cop count toward starvation.
                        if (cop_req && (skip_q != SKIP_MAX)) begin
                            skip_d = skip_q + 4'd1;
                        end else begin
                            skip_d = skip_q;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (rom_ack) begin
                    rom_req_d = 1'b0;
                    state_d   = RELEASE;
                    if (owner_q == OWNER_COP) begin
                        cop_q_d   = lane_s;
                        cop_ack_d = 1'b1;
                    end else begin
                        cpu_q_d   = lane_s;
                        cpu_ack_d = 1'b1;
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                rom_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            rom_word_q <= 1'b0;
            owner_q    <= OWNER_CPU;
            skip_q     <= 4'd0;
            cpu_ack_q  <= 1'b0;
            cop_ack_q  <= 1'b0;
            cpu_q_q    <= 16'h0000;
            cop_q_q    <= 16'h0000;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            rom_word_q <= rom_word_d;
            owner_q    <= owner_d;
            skip_q     <= skip_d;
            cpu_ack_q  <= cpu_ack_d;
            cop_ack_q  <= cop_ack_d;
            cpu_q_q    <= cpu_q_d;
            cop_q_q    <= cop_q_d;
            busy_q     <= busy_d;
        end
    end

    assign rom_req  = rom_req_q;
    assign rom_addr = rom_addr_q;
    assign rom_word = rom_word_q;
    assign owner    = owner_q;
    assign cpu_ack  = cpu_ack_q;
    assign cop_ack  = cop_ack_q;
    assign cpu_q    = cpu_q_q;
    assign cop_q    = cop_q_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: a small ROM responder model plus
// hand-computed expectations for each scenario.
module tb_rom_port_arbiter;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        refresh;
    logic [23:0] rom_mask;
    logic        cpu_req, cpu_word, cpu_ack;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_q;
    logic        cop_req, cop_word, cop_ack;
    logic [23:0] cop_addr;
    logic [15:0] cop_q;
    logic        rom_req, rom_word, rom_ack;
    logic [23:0] rom_addr;
    logic [15:0] rom_q;
    logic        busy, owner;

    int n_cmp = 0;
    int n_bad = 0;

    // responder controls and grant log
    logic        resp_en;
    int          ack_delay;
    logic [15:0] rom_data;
    int          wait_cnt;
    int          log_n;
    logic        log_owner [0:63];
    logic [23:0] log_addr  [0:63];
    logic        log_word  [0:63];

    int cpu_ack_cnt = 0;
    int cop_ack_cnt = 0;
    int both_ack_cnt = 0;

    rom_port_arbiter #(.ADDR_W(24), .MAX_SKIP(3)) dut (
        .mclk(mclk), .rst_n(rst_n), .refresh(refresh), .rom_mask(rom_mask),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_word(cpu_word),
        .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .cop_req(cop_req), .cop_addr(cop_addr), .cop_word(cop_word),
        .cop_ack(cop_ack), .cop_q(cop_q),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_word(rom_word),
        .rom_ack(rom_ack), .rom_q(rom_q),
        .busy(busy), .owner(owner)
    );

    always #5 mclk = ~mclk;

    // Ack pulse monitor.
    always @(negedge mclk) begin
        if (cpu_ack) cpu_ack_cnt++;
        if (cop_ack) cop_ack_cnt++;
        if (cpu_ack && cop_ack) both_ack_cnt++;
    end

    // ROM controller model: acks ack_delay cycles after seeing rom_req.
    initial begin
        rom_ack  = 1'b0;
        rom_q    = 16'h0000;
        wait_cnt = 0;
        log_n    = 0;
        forever begin
            @(negedge mclk);
            if (resp_en) begin
                rom_ack = 1'b0;
                if (rom_req) begin
                    if (wait_cnt >= ack_delay) begin
                        rom_ack  = 1'b1;
                        rom_q    = rom_data;
                        wait_cnt = 0;
                        if (log_n < 64) begin
                            log_owner[log_n] = owner;
                            log_addr[log_n]  = rom_addr;
                            log_word[log_n]  = rom_word;
                        end
                        log_n++;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic port, input int budget, output logic seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge mclk);
            cycles++;
            seen = port ? cop_ack : cpu_ack;
        end
    endtask

    initial begin
        logic seen;
        int   lat, base, cbase, obase, hi_cnt;
        logic exp_owner;

        rst_n = 1'b0; refresh = 1'b0; rom_mask = 24'hFFFFFF;
        cpu_req = 1'b0; cpu_addr = 24'h000000; cpu_word = 1'b0;
        cop_req = 1'b0; cop_addr = 24'h000000; cop_word = 1'b0;
        resp_en = 1'b1; ack_delay = 0; rom_data = 16'h0000;
        repeat (3) @(negedge mclk);

        chk_eq("rst_rom_req", 32'(rom_req), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_owner", 32'(owner), 32'd0);
        chk_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk_eq("rst_cpu_q", 32'(cpu_q), 32'd0);
        chk_eq("rst_cop_q", 32'(cop_q), 32'd0);
        rst_n = 1'b1;
        @(negedge mclk);

        // CPU byte read, odd address, ROM acks after 2 wait cycles
        cbase = cpu_ack_cnt; obase = cop_ack_cnt;
        ack_delay = 2; rom_data = 16'hABCD;
        cpu_addr = 24'h012345; cpu_word = 1'b0; cpu_req = 1'b1;
        wait_ack(1'b0, 20, seen, lat);
        cpu_req = 1'b0;
        chk_eq("t1_ack_seen", 32'(seen), 32'd1);
        chk_eq("t1_latency", 32'(lat), 32'd4);
        chk_eq("t1_rom_addr", 32'(log_addr[0]), 32'h012345);
        chk_eq("t1_rom_word", 32'(log_word[0]), 32'd0);
        chk_eq("t1_cpu_q", 32'(cpu_q), 32'h00AB);
        repeat (3) @(negedge mclk);
        chk_eq("t1_cpu_ack_pulses", 32'(cpu_ack_cnt - cbase), 32'd1);
        chk_eq("t1_cop_ack_pulses", 32'(cop_ack_cnt - obase), 32'd0);
        chk_eq("t1_idle_busy", 32'(busy), 32'd0);

        // Cop word read with address mask
        ack_delay = 1; rom_data = 16'h5AA5; rom_mask = 24'h0FFFFF;
        base = log_n;
        cop_addr = 24'h3FFFFE; cop_word = 1'b1; cop_req = 1'b1;
        wait_ack(1'b1, 20, seen, lat);
        cop_req = 1'b0;
        chk_eq("t2_ack_seen", 32'(seen), 32'd1);
        chk_eq("t2_rom_addr", 32'(log_addr[base]), 32'h0FFFFE);
        chk_eq("t2_rom_word", 32'(log_word[base]), 32'd1);
        chk_eq("t2_cop_q", 32'(cop_q), 32'h5AA5);
        chk_eq("t2_cpu_q_held", 32'(cpu_q), 32'h00AB);
        chk_eq("t2_owner", 32'(owner), 32'd1);
        rom_mask = 24'hFFFFFF;
        repeat (2) @(negedge mclk);

        // Both requesting continuously: cpu x3 then cop, repeating
        ack_delay = 0; rom_data = 16'h0F0F;
        base = log_n;
        cpu_addr = 24'h000100; cpu_word = 1'b1;
        cop_addr = 24'h000200; cop_word = 1'b1;
        cpu_req = 1'b1; cop_req = 1'b1;
        lat = 0;
        while (log_n < base + 8 && lat < 60) begin
            @(negedge mclk);
            lat++;
        end
        cpu_req = 1'b0; cop_req = 1'b0;
        chk_eq("t3_grant_count", 32'(log_n - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            exp_owner = ((i % 4) == 3) ? 1'b1 : 1'b0;
            chk_eq($sformatf("t3_grant%0d_owner", i), 32'(log_owner[base + i]), 32'(exp_owner));
        end
        repeat (3) @(negedge mclk);

        // Refresh blocks new grants; released on first refresh-free cycle
        refresh = 1'b1; ack_delay = 0;
        cop_addr = 24'h000300; cop_word = 1'b0; cop_req = 1'b1;
        hi_cnt = 0;
        repeat (10) begin
            @(negedge mclk);
            if (rom_req) hi_cnt++;
        end
        chk_eq("t4_refresh_block", 32'(hi_cnt), 32'd0);
        refresh = 1'b0;
        @(negedge mclk);
        chk_eq("t4_rom_req_rise", 32'(rom_req), 32'd1);
        wait_ack(1'b1, 10, seen, lat);
        cop_req = 1'b0;
        chk_eq("t4_ack_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge mclk);

        // Refresh rising mid-access does not disturb it
        ack_delay = 3; rom_data = 16'h1111;
        cpu_addr = 24'h000400; cpu_word = 1'b1; cpu_req = 1'b1;
        @(negedge mclk);
        refresh = 1'b1;
        @(negedge mclk);
        chk_eq("t5_req_held_a", 32'(rom_req), 32'd1);
        @(negedge mclk);
        chk_eq("t5_req_held_b", 32'(rom_req), 32'd1);
        wait_ack(1'b0, 10, seen, lat);
        cpu_req = 1'b0;
        chk_eq("t5_ack_seen", 32'(seen), 32'd1);
        chk_eq("t5_cpu_q", 32'(cpu_q), 32'h1111);
        repeat (2) @(negedge mclk);
        refresh = 1'b0;
        @(negedge mclk);

        // Reset during GRANT, stray rom_ack afterwards is ignored
        resp_en = 1'b0; rom_ack = 1'b0;
        cpu_addr = 24'h000500; cpu_word = 1'b1; cpu_req = 1'b1;
        @(negedge mclk);
        chk_eq("t6_in_grant", 32'(rom_req), 32'd1);
        cbase = cpu_ack_cnt; obase = cop_ack_cnt;
        rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
        @(negedge mclk);
        rom_ack = 1'b1; rom_q = 16'hFFFF;
        @(negedge mclk);
        rom_ack = 1'b0;
        @(negedge mclk);
        chk_eq("t6_rom_req", 32'(rom_req), 32'd0);
        chk_eq("t6_busy", 32'(busy), 32'd0);
        chk_eq("t6_cpu_q", 32'(cpu_q), 32'd0);
        chk_eq("t6_no_cpu_ack", 32'(cpu_ack_cnt - cbase), 32'd0);
        chk_eq("t6_no_cop_ack", 32'(cop_ack_cnt - obase), 32'd0);
        resp_en = 1'b1; ack_delay = 0; rom_data = 16'h1234;
        cpu_addr = 24'h000010; cpu_word = 1'b0; cpu_req = 1'b1;
        wait_ack(1'b0, 10, seen, lat);
        cpu_req = 1'b0;
        chk_eq("t6_post_ack", 32'(seen), 32'd1);
        chk_eq("t6_post_cpu_q", 32'(cpu_q), 32'h0034);
        repeat (2) @(negedge mclk);

        // Handoff on the RELEASE edge: cpu once, then cop, no stale re-grant
        base = log_n; cbase = cpu_ack_cnt;
        ack_delay = 0; rom_data = 16'hBEEF;
        cpu_addr = 24'h000020; cpu_word = 1'b1; cpu_req = 1'b1;
        wait_ack(1'b0, 10, seen, lat);
        chk_eq("t7_cpu_latency", 32'(lat), 32'd2);
        cpu_req = 1'b0;
        cop_addr = 24'h000040; cop_word = 1'b1; cop_req = 1'b1;
        wait_ack(1'b1, 10, seen, lat);
        cop_req = 1'b0;
        chk_eq("t7_cop_ack", 32'(seen), 32'd1);
        chk_eq("t7_cop_latency", 32'(lat), 32'd3);
        repeat (3) @(negedge mclk);
        chk_eq("t7_grants", 32'(log_n - base), 32'd2);
        chk_eq("t7_first_owner", 32'(log_owner[base]), 32'd0);
        chk_eq("t7_second_owner", 32'(log_owner[base + 1]), 32'd1);
        chk_eq("t7_cpu_acks", 32'(cpu_ack_cnt - cbase), 32'd1);
        chk_eq("t7_cop_q", 32'(cop_q), 32'hBEEF);

        chk_eq("never_both_ack", 32'(both_ack_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
